// File: rtl/jump_pipe_unit.sv
// Pipelined JAL/JALR/AUIPC execution unit with elastic stages,
// ROB-ordered flush and a one-shot frontend redirect per jump.
module jump_pipe_unit #(
   parameter int XLEN       = 64,
   parameter int VADDR_BITS = 39,
   parameter int ROB_BITS   = 5,
   parameter int FTQ_BITS   = 3,
   parameter int STAGES     = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_src0,
   input  logic [VADDR_BITS-1:0] in_src1,
   input  logic [VADDR_BITS-1:0] in_pc,
   input  logic                  in_is_rvc,
   input  logic                  in_pred_taken,
   input  logic [6:0]            in_func,
   input  logic [19:0]           in_imm,
   input  logic                  in_rob_flag,
   input  logic [ROB_BITS-1:0]   in_rob_value,
   input  logic                  in_ftq_flag,
   input  logic [FTQ_BITS-1:0]   in_ftq_value,
   input  logic [2:0]            in_ftq_offset,
   input  logic [5:0]            in_pdest,
   input  logic                  in_rf_wen,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_data,
   output logic [5:0]            out_pdest,
   output logic                  out_rf_wen,
   output logic                  out_rob_flag,
   output logic [ROB_BITS-1:0]   out_rob_value,
   output logic                  redir_valid,
   output logic                  redir_rob_flag,
   output logic [ROB_BITS-1:0]   redir_rob_value,
   output logic                  redir_ftq_flag,
   output logic [FTQ_BITS-1:0]   redir_ftq_value,
   output logic [2:0]            redir_ftq_offset,
   output logic [VADDR_BITS-1:0] redir_target,
   output logic                  redir_mispred,
   input  logic                  flush_valid,
   input  logic                  flush_rob_flag,
   input  logic [ROB_BITS-1:0]   flush_rob_value,
   input  logic                  flush_level
);

   localparam int N = STAGES;

   typedef struct packed {
      logic [XLEN-1:0]       data;
      logic [VADDR_BITS-1:0] target;
      logic [VADDR_BITS-1:0] pred;
      logic                  taken;
      logic                  mispred;
      logic                  auipc;
      logic [5:0]            pdest;
      logic                  rf_wen;
      logic                  rob_flag;
      logic [ROB_BITS-1:0]   rob_value;
      logic                  ftq_flag;
      logic [FTQ_BITS-1:0]   ftq_value;
      logic [2:0]            ftq_offset;
   } pay_t;

   function automatic logic kill_f(
      input logic                ef,
      input logic [ROB_BITS-1:0] ev
   );
      logic after;
      logic same;
      after = (ef ^ flush_rob_flag) ^ (ev > flush_rob_value);
      same  = (ef == flush_rob_flag) && (ev == flush_rob_value);
      return flush_valid & (after | (flush_level & same));
   endfunction

   function automatic logic mis_f(
      input logic [VADDR_BITS-1:0] tgt,
      input logic [VADDR_BITS-1:0] pred,
      input logic                  taken
   );
      return (tgt != pred) | ~taken;
   endfunction

   logic            is_jalr;
   logic            is_auipc;
   logic [XLEN-1:0] pc_x;
   logic [XLEN-1:0] off;
   logic [XLEN-1:0] snpc;
   logic [XLEN-1:0] sum_pc;
   logic [XLEN-1:0] tgt_full;
   pay_t            in_pay;

   always_comb begin
      is_jalr  = (in_func[1:0] == 2'b01);
      is_auipc = (in_func[1:0] == 2'b10);
      pc_x = {{(XLEN-VADDR_BITS){in_pc[VADDR_BITS-1]}}, in_pc};
      unique case (1'b1)
         is_jalr:  off = {{(XLEN-12){in_imm[11]}}, in_imm[11:0]};
         is_auipc: off = {{(XLEN-32){in_imm[19]}}, in_imm, 12'b0};
         default:  off = {{(XLEN-21){in_imm[19]}}, in_imm, 1'b0};
      endcase
      snpc     = pc_x + (in_is_rvc ? XLEN'(2) : XLEN'(4));
      sum_pc   = pc_x + off;
      tgt_full = is_jalr ? ((in_src0 + off) & ~XLEN'(1)) : sum_pc;

      in_pay            = '0;
      in_pay.data       = is_auipc ? sum_pc : snpc;
      in_pay.target     = tgt_full[VADDR_BITS-1:0];
      in_pay.pred       = in_src1;
      in_pay.taken      = in_pred_taken;
      in_pay.auipc      = is_auipc;
      in_pay.pdest      = in_pdest;
      in_pay.rf_wen     = in_rf_wen;
      in_pay.rob_flag   = in_rob_flag;
      in_pay.rob_value  = in_rob_value;
      in_pay.ftq_flag   = in_ftq_flag;
      in_pay.ftq_value  = in_ftq_value;
      in_pay.ftq_offset = in_ftq_offset;
      // single-stage build has no S2, so resolve mispredict before S1
      if (N == 1) begin
         in_pay.mispred = mis_f(in_pay.target, in_src1, in_pred_taken);
      end
   end

   logic [N-1:0] vld_q;
   logic [N-1:0] vld_d;
   logic [N-1:0] live;
   logic [N-1:0] go;
   pay_t         pay_q [N];
   pay_t         pay_d [N];
   logic         kill_in;

   always_comb begin
      kill_in = kill_f(in_rob_flag, in_rob_value);
      for (int i = 0; i < N; i++) begin
         live[i] = vld_q[i] &
            ~kill_f(pay_q[i].rob_flag, pay_q[i].rob_value);
      end

      // a killed slot counts as empty so upstream can refill it
      go[N-1] = ~live[N-1] | out_ready;
      for (int i = N-2; i >= 0; i--) begin
         go[i] = ~live[i] | go[i+1];
      end

      for (int i = 0; i < N; i++) begin
         vld_d[i] = live[i];
         pay_d[i] = pay_q[i];
      end

      if (go[0]) begin
         vld_d[0] = in_valid & ~kill_in;
         if (in_valid & ~kill_in) begin
            pay_d[0] = in_pay;
         end
      end

      for (int i = 1; i < N; i++) begin
         if (go[i]) begin
            vld_d[i] = live[i-1];
            if (live[i-1]) begin
               pay_d[i] = pay_q[i-1];
               if (i == 1) begin
                  pay_d[i].mispred = mis_f(pay_q[0].target,
                     pay_q[0].pred, pay_q[0].taken);
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < N; i++) begin
            pay_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         pay_q <= pay_d;
      end
   end

   assign in_ready         = go[0];
   assign out_valid        = live[N-1];
   assign out_data         = pay_q[N-1].data;
   assign out_pdest        = pay_q[N-1].pdest;
   assign out_rf_wen       = pay_q[N-1].rf_wen;
   assign out_rob_flag     = pay_q[N-1].rob_flag;
   assign out_rob_value    = pay_q[N-1].rob_value;
   assign redir_valid      = live[N-1] & out_ready & ~pay_q[N-1].auipc;
   assign redir_rob_flag   = pay_q[N-1].rob_flag;
   assign redir_rob_value  = pay_q[N-1].rob_value;
   assign redir_ftq_flag   = pay_q[N-1].ftq_flag;
   assign redir_ftq_value  = pay_q[N-1].ftq_value;
   assign redir_ftq_offset = pay_q[N-1].ftq_offset;
   assign redir_target     = pay_q[N-1].target;
   assign redir_mispred    = pay_q[N-1].mispred;

   logic unused_bits;
   assign unused_bits = ^{in_func[6:2], tgt_full};

endmodule

// File: tb/tb_jump_pipe_unit.sv
// Directed bench for jump_pipe_unit: a 2-stage and a 3-stage instance
// share stimulus; each scenario checks the instance it targets.
module tb_jump_pipe_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_src0;
   logic [38:0] in_src1;
   logic [38:0] in_pc;
   logic        in_is_rvc;
   logic        in_pred_taken;
   logic [6:0]  in_func;
   logic [19:0] in_imm;
   logic        in_rob_flag;
   logic [4:0]  in_rob_value;
   logic        in_ftq_flag;
   logic [2:0]  in_ftq_value;
   logic [2:0]  in_ftq_offset;
   logic [5:0]  in_pdest;
   logic        in_rf_wen;
   logic        out_ready;
   logic        flush_valid;
   logic        flush_rob_flag;
   logic [4:0]  flush_rob_value;
   logic        flush_level;

   logic        a_in_ready, a_out_valid, a_out_rf_wen, a_out_rob_flag;
   logic [63:0] a_out_data;
   logic [5:0]  a_out_pdest;
   logic [4:0]  a_out_rob_value, a_redir_rob_value;
   logic        a_redir_valid, a_redir_rob_flag, a_redir_ftq_flag;
   logic [2:0]  a_redir_ftq_value, a_redir_ftq_offset;
   logic [38:0] a_redir_target;
   logic        a_redir_mispred;

   logic        b_in_ready, b_out_valid, b_out_rf_wen, b_out_rob_flag;
   logic [63:0] b_out_data;
   logic [5:0]  b_out_pdest;
   logic [4:0]  b_out_rob_value, b_redir_rob_value;
   logic        b_redir_valid, b_redir_rob_flag, b_redir_ftq_flag;
   logic [2:0]  b_redir_ftq_value, b_redir_ftq_offset;
   logic [38:0] b_redir_target;
   logic        b_redir_mispred;

   int n_chk = 0;
   int n_err = 0;
   logic [5:0] seen[$];

   always #5 clk = ~clk;

   jump_pipe_unit #(.STAGES(2)) u_dut2 (
      .clock(clk), .reset(rst),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_src0(in_src0), .in_src1(in_src1), .in_pc(in_pc),
      .in_is_rvc(in_is_rvc), .in_pred_taken(in_pred_taken),
      .in_func(in_func), .in_imm(in_imm),
      .in_rob_flag(in_rob_flag), .in_rob_value(in_rob_value),
      .in_ftq_flag(in_ftq_flag), .in_ftq_value(in_ftq_value),
      .in_ftq_offset(in_ftq_offset), .in_pdest(in_pdest),
      .in_rf_wen(in_rf_wen),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_pdest(a_out_pdest),
      .out_rf_wen(a_out_rf_wen), .out_rob_flag(a_out_rob_flag),
      .out_rob_value(a_out_rob_value),
      .redir_valid(a_redir_valid),
      .redir_rob_flag(a_redir_rob_flag),
      .redir_rob_value(a_redir_rob_value),
      .redir_ftq_flag(a_redir_ftq_flag),
      .redir_ftq_value(a_redir_ftq_value),
      .redir_ftq_offset(a_redir_ftq_offset),
      .redir_target(a_redir_target),
      .redir_mispred(a_redir_mispred),
      .flush_valid(flush_valid), .flush_rob_flag(flush_rob_flag),
      .flush_rob_value(flush_rob_value), .flush_level(flush_level)
   );

   jump_pipe_unit #(.STAGES(3)) u_dut3 (
      .clock(clk), .reset(rst),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_src0(in_src0), .in_src1(in_src1), .in_pc(in_pc),
      .in_is_rvc(in_is_rvc), .in_pred_taken(in_pred_taken),
      .in_func(in_func), .in_imm(in_imm),
      .in_rob_flag(in_rob_flag), .in_rob_value(in_rob_value),
      .in_ftq_flag(in_ftq_flag), .in_ftq_value(in_ftq_value),
      .in_ftq_offset(in_ftq_offset), .in_pdest(in_pdest),
      .in_rf_wen(in_rf_wen),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_pdest(b_out_pdest),
      .out_rf_wen(b_out_rf_wen), .out_rob_flag(b_out_rob_flag),
      .out_rob_value(b_out_rob_value),
      .redir_valid(b_redir_valid),
      .redir_rob_flag(b_redir_rob_flag),
      .redir_rob_value(b_redir_rob_value),
      .redir_ftq_flag(b_redir_ftq_flag),
      .redir_ftq_value(b_redir_ftq_value),
      .redir_ftq_offset(b_redir_ftq_offset),
      .redir_target(b_redir_target),
      .redir_mispred(b_redir_mispred),
      .flush_valid(flush_valid), .flush_rob_flag(flush_rob_flag),
      .flush_rob_value(flush_rob_value), .flush_level(flush_level)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] fn, input logic [38:0] pc,
                        input logic [63:0] s0, input logic [38:0] s1,
                        input logic [19:0] imm, input logic rvc,
                        input logic tk, input logic rf,
                        input logic [4:0] rv);
      in_valid      = 1'b1;
      in_func       = {5'b0, fn};
      in_pc         = pc;
      in_src0       = s0;
      in_src1       = s1;
      in_imm        = imm;
      in_is_rvc     = rvc;
      in_pred_taken = tk;
      in_rob_flag   = rf;
      in_rob_value  = rv;
   endtask

   task automatic flush(input logic f, input logic [4:0] v,
                        input logic lvl);
      flush_valid     = 1'b1;
      flush_rob_flag  = f;
      flush_rob_value = v;
      flush_level     = lvl;
   endtask

   task automatic drain();
      in_valid    = 1'b0;
      flush_valid = 1'b0;
      out_ready   = 1'b1;
      repeat (6) begin
         if (b_out_valid) seen.push_back({b_out_rob_flag, b_out_rob_value});
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int idx;
      int got;
      int cnt;
      rst = 1'b1;
      in_valid = 0; in_src0 = 0; in_src1 = 0; in_pc = 0;
      in_is_rvc = 0; in_pred_taken = 0; in_func = 0; in_imm = 0;
      in_rob_flag = 0; in_rob_value = 0; in_ftq_flag = 1'b1;
      in_ftq_value = 3'd6; in_ftq_offset = 3'd5; in_pdest = 6'h2a;
      in_rf_wen = 1'b1; out_ready = 1'b1; flush_valid = 0;
      flush_rob_flag = 0; flush_rob_value = 0; flush_level = 0;
      tick();
      tick();
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_redir_valid", a_redir_valid, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_data", a_out_data, 0);
      chk("rst_mispred", a_redir_mispred, 0);
      chk("rst_out_valid3", b_out_valid, 0);
      rst = 1'b0;

      // JAL, correctly predicted
      drive(2'b00, 39'h80000000, 64'h0, 39'h80000020, 20'h00010,
            1'b0, 1'b1, 1'b0, 5'd1);
      #1;
      chk("jal_in_ready", a_in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("jal_lat1_valid", a_out_valid, 0);
      tick();
      chk("jal_out_valid", a_out_valid, 1);
      chk("jal_data", a_out_data, 64'h80000004);
      chk("jal_redir_valid", a_redir_valid, 1);
      chk("jal_target", a_redir_target, 39'h80000020);
      chk("jal_mispred", a_redir_mispred, 0);
      chk("jal_pdest", a_out_pdest, 6'h2a);
      chk("jal_ftq_off", a_redir_ftq_offset, 3'd5);
      chk("jal_rob", a_redir_rob_value, 5'd1);
      tick();
      chk("jal_gone", a_out_valid, 0);

      // JALR, compressed, target mismatch
      drive(2'b01, 39'h2000, 64'h1003, 39'h1000, 20'h00004,
            1'b1, 1'b1, 1'b0, 5'd2);
      tick();
      in_valid = 1'b0;
      tick();
      chk("jalr_out_valid", a_out_valid, 1);
      chk("jalr_data", a_out_data, 64'h2002);
      chk("jalr_target", a_redir_target, 39'h1006);
      chk("jalr_mispred", a_redir_mispred, 1);
      chk("jalr_redir_valid", a_redir_valid, 1);
      tick();

      // AUIPC never redirects
      drive(2'b10, 39'h4000, 64'h0, 39'h0, 20'h00001,
            1'b0, 1'b1, 1'b0, 5'd3);
      #1;
      chk("auipc_redir_c0", a_redir_valid, 0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("auipc_redir_c1", a_redir_valid, 0);
      tick();
      chk("auipc_out_valid", a_out_valid, 1);
      chk("auipc_data", a_out_data, 64'h5000);
      chk("auipc_redir_c2", a_redir_valid, 0);
      tick();
      tick();

      // backpressure on the 3-stage instance
      idx = 0;
      got = 0;
      for (int c = 0; c < 14; c++) begin
         out_ready = (c >= 5);
         if (idx < 4)
            drive(2'b00, 39'(256 * (idx + 1)), 64'h0, 39'h0, 20'h8,
                  1'b0, 1'b1, 1'b0, 5'(10 + idx));
         else
            in_valid = 1'b0;
         #1;
         if (c == 3) chk("bp_in_ready_full", b_in_ready, 0);
         if (c == 3 || c == 4) begin
            chk("bp_hold_valid", b_out_valid, 1);
            chk("bp_hold_data", b_out_data, 64'h104);
            chk("bp_hold_redir", b_redir_valid, 0);
         end
         if (b_out_valid && out_ready) begin
            chk("bp_order", b_out_data, 64'(256 * (got + 1) + 4));
            got++;
         end
         if (in_valid && b_in_ready) idx++;
         tick();
      end
      chk("bp_count", 64'(got), 4);
      in_valid = 1'b0;
      tick();
      tick();

      // flush (0,4) level 0 with incoming (0,6)
      seen.delete();
      out_ready = 1'b0;
      for (int k = 3; k <= 5; k++) begin
         drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0,
               1'b0, 1'b1, 1'b0, 5'(k));
         tick();
      end
      flush(1'b0, 5'd4, 1'b0);
      drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd6);
      #1;
      chk("fl0_sn_alive", b_out_valid, 1);
      chk("fl0_in_ready", b_in_ready, 1);
      tick();
      drain();
      chk("fl0_count", 64'(seen.size()), 2);
      chk("fl0_first", (seen.size() > 0) ? seen[0] : 6'h3f, 6'h03);
      chk("fl0_second", (seen.size() > 1) ? seen[1] : 6'h3f, 6'h04);

      // flush (0,4) level 1 with incoming (0,2)
      seen.delete();
      out_ready = 1'b0;
      for (int k = 3; k <= 5; k++) begin
         drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0,
               1'b0, 1'b1, 1'b0, 5'(k));
         tick();
      end
      flush(1'b0, 5'd4, 1'b1);
      drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd2);
      #1;
      chk("fl1_sn_alive", b_out_valid, 1);
      tick();
      drain();
      chk("fl1_count", 64'(seen.size()), 2);
      chk("fl1_first", (seen.size() > 0) ? seen[0] : 6'h3f, 6'h03);
      chk("fl1_second", (seen.size() > 1) ? seen[1] : 6'h3f, 6'h02);

      // wrap: flush (0,30) kills (1,1) sitting in SN while out_ready=1
      seen.delete();
      out_ready = 1'b0;
      drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b1, 5'd1);
      tick();
      drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd29);
      tick();
      drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd28);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      flush(1'b0, 5'd30, 1'b0);
      #1;
      chk("wrap_out_valid", b_out_valid, 0);
      chk("wrap_redir_valid", b_redir_valid, 0);
      tick();
      drain();
      chk("wrap_count", 64'(seen.size()), 2);
      chk("wrap_first", (seen.size() > 0) ? seen[0] : 6'h3f, 6'd29);
      chk("wrap_second", (seen.size() > 1) ? seen[1] : 6'h3f, 6'd28);

      // reset with two ops in flight plus a fire in the reset cycle
      out_ready = 1'b0;
      drive(2'b00, 39'h100, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd7);
      tick();
      drive(2'b00, 39'h200, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd8);
      tick();
      chk("prerst_valid", a_out_valid, 1);
      rst = 1'b1;
      drive(2'b00, 39'h300, 64'h0, 39'h0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd9);
      tick();
      in_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid", a_out_valid, 0);
      chk("mid_rst_redir", a_redir_valid, 0);
      chk("mid_rst_in_ready", a_in_ready, 1);
      chk("mid_rst_out_valid3", b_out_valid, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      repeat (5) begin
         if (a_out_valid || b_out_valid) cnt++;
         tick();
      end
      chk("rst_no_stale", 64'(cnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/jump_pipe_unit.md
# jump_pipe_unit

Parametrised, pipelined successor to the single-cycle jump execution unit in the integer issue path. It executes JAL, JALR and AUIPC and produces the link/AUIPC writeback value. For jumps it also produces a frontend redirect (target plus misprediction flag). It adds a configurable register pipeline with per-stage ready/valid backpressure and ROB-ordered flush, neither of which the combinational unit has.

## Interface
- XLEN, 64, data width
- VADDR_BITS, 39, virtual PC/target width; PC is sign-extended from bit VADDR_BITS-1 to XLEN
- ROB_BITS, 5, robIdx value width
- FTQ_BITS, 3, ftqPtr value width
- STAGES, 2, pipeline depth; legal range 1..4
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_valid / in_ready  in / out  1  issue handshake
- in_src0  in  XLEN  rs1 value
- in_src1  in  VADDR_BITS  predicted jump target
- in_pc  in  VADDR_BITS  instruction PC
- in_is_rvc, in_pred_taken  in  1 each
- in_func  in  7  fuOpType; bits [1:0]: 00 JAL, 01 JALR, 10 AUIPC, 11 reserved (treated as JAL)
- in_imm  in  20  compressed immediate
- in_rob_flag  in  1  robIdx flag
- in_rob_value  in  ROB_BITS  robIdx value
- in_ftq_flag  in  1  ftqPtr flag
- in_ftq_value  in  FTQ_BITS  ftqPtr value
- in_ftq_offset  in  3
- in_pdest  in  6
- in_rf_wen  in  1
- out_valid / out_ready  out / in  1  writeback handshake
- out_data  out  XLEN
- out_pdest, out_rf_wen, out_rob_flag, out_rob_value  out  as inputs
- redir_valid  out  1
- redir_rob_flag/value, redir_ftq_flag/value, redir_ftq_offset  out  as inputs
- redir_target  out  VADDR_BITS
- redir_mispred  out  1
- flush_valid  in  1
- flush_rob_flag  in  1
- flush_rob_value  in  ROB_BITS
- flush_level  in  1  1 = also kill the flushing robIdx itself

## Operation
- Offset, all sign-extended to XLEN:
  - JALR: sext(imm[11:0])
  - JAL: sext({imm,1'b0})
  - AUIPC: sext({imm,12'b0})
- Results:
  - snpc = pc + (is_rvc ? 2 : 4)
  - data = AUIPC ? pc+offset : snpc
  - target = JALR ? (src0+offset) & ~1 : pc+offset
  - all sums taken modulo 2^XLEN
- Misprediction: mispred = (target[VADDR_BITS-1:0] != src1) | ~pred_taken.
- Pipeline: STAGES slots S1..SN, each with a valid bit and a payload.
  - Offset and adds are computed combinationally before S1 and captured in S1.
  - mispred is computed from S1 contents and captured into S2 (or directly into S1 when STAGES=1).
  - Later stages pass the payload through unchanged.
- Handshake: elastic per stage.
  - Si advances when S(i+1) is empty or advancing.
  - SN advances on out_ready.
  - in_ready = ~S1.valid | S1 advances.
  - in_ready does not depend combinationally on in_valid.
- Outputs: out_* reflect SN; out_valid = SN.valid.
  - redir_valid = SN.valid & out_ready & ~AUIPC & ~killed, i.e. exactly one cycle per jump, in its writeback cycle.
- Flush: while flush_valid, an entry (flag e, value v) is killed if:
  - isAfter(e, f): (e.flag ^ f.flag) ^ (v > f.value), or
  - flush_level = 1 and the entry robIdx equals the flush robIdx.
- Flush kill rules:
  - The kill applies to every stage and to the incoming beat in the same cycle; killed entries have their valid cleared.
  - A killed SN entry produces neither out_valid nor redir_valid in that cycle.
  - Stages never hold bubbles; a killed slot is simply empty.

## Timing
- Latency is STAGES cycles from in fire to out_valid without stalls; throughput is 1 op/cycle.
- Reset:
  - All valid bits and payload registers go to 0.
  - out_valid=0, redir_valid=0, all data/index outputs=0, redir_mispred=0, in_ready=1 in the cycle after reset asserts.
  - Reset mid-operation discards all in-flight ops.
  - Reset overrides flush and input fire.
- Full (all stages valid, out_ready=0): in_ready=0 and payloads hold stable.
- Simultaneous flush and in fire of a killed op: the op is not captured. A non-killed op is captured normally.
- Simultaneous flush and out fire of a killed SN: the beat is suppressed and S(N-1) may still advance.
- robIdx wrap-around is handled solely by the flag term of isAfter.
- Outputs must be stable while out_valid=1 and out_ready=0.

## Test plan
- JAL, STAGES=2, pc=0x80000000, imm=0x00010, pred_taken=1, src1=0x80000020 -> after 2 cycles: out_data=0x80000004, redir_valid=1, redir_target=0x80000020, redir_mispred=0.
- JALR, src0=0x1003, imm=0x00004, is_rvc=1, pc=0x2000, src1=0x1000 -> target=0x1006, out_data=0x2002, redir_mispred=1.
- AUIPC, pc=0x4000, imm=0x00001 -> out_data=0x5000; redir_valid stays 0 throughout.
- Backpressure: 4 back-to-back ops with out_ready=0 for 5 cycles, STAGES=3 -> in_ready drops after 3 accepted; out_* held stable; all 4 emerge in order once out_ready=1.
- Flush: entries rob (0,3),(0,4),(0,5) in flight; flush rob (0,4), level=0 -> only (0,5) killed. Repeat with level=1 -> (0,4) and (0,5) killed. Wrap case: flush (0,30) kills entry (1,1).
- Reset asserted with 2 ops in flight -> next cycle out_valid=0, redir_valid=0, in_ready=1; no stale beat appears afterwards.
